mtm_alu_out_sched: RTL and testbench
====================================

# mtm_alu_out_sched

Output scheduler sitting between the ALU core and the `mtm_Alu_serializer`. It buffers normal results in a small FIFO, holds one pending error response, and picks which one goes next; error responses win. It drives the serializer's `C`/`CTL_in` inputs for exactly one cycle per frame. It then enforces a hold-off for the duration of the serial frame so that no issue is ever lost or overlapped.

## Interface
- `DEPTH`, 4: result FIFO depth (power of two, ≥2).
- `BYTE_CYCLES`, 11: serializer clocks per byte (start + packet + 8 data + stop).
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `res_valid`  in  1  core presents a normal result.
- `res_C`  in  32  result data.
- `res_CTL`  in  8  result control byte; bit 7 must be 0.
- `res_ready`  out  1  FIFO not full; push happens when `res_valid && res_ready`.
- `err_valid`  in  1  core reports an error response (single-cycle pulse).
- `err_CTL`  in  8  error code: `8'b11001001`, `8'b10010011` or `8'b10100101`.
- `ser_C`  out  32  to serializer `C`.
- `ser_CTL`  out  8  to serializer `CTL_in`; `IDLE_CTL = 8'hFF` when not issuing.
- `busy`  out  1  frame in flight (WAIT state).
- `err_overflow`  out  1  sticky: an error was dropped because the error slot was full.
- `bad_ctl`  out  1  sticky: an input had an illegal CTL and was dropped.

## Operation
- Reset values: `ser_C=0`, `ser_CTL=8'hFF`, `busy=0`, `err_overflow=0`, `bad_ctl=0`, FIFO empty, `res_ready=1`, error slot empty, state IDLE, hold counter 0.
- Push: a valid result with `res_CTL[7]==1` is not stored. `bad_ctl` sets and `res_ready` still reads 1 for that beat.
- Error slot: one entry. A legal `err_CTL` on `err_valid` loads it. If the slot is already full, the new error is dropped and `err_overflow` sets (first error kept). An illegal code is dropped and sets `bad_ctl`. Sticky flags clear only on reset.
- FSM states:
  - IDLE: if the error slot is full, go to ISSUE_ERR. Else if the FIFO is not empty, go to ISSUE_RES. Else stay.
  - ISSUE_ERR: drive `ser_CTL=slot`, `ser_C=0` for one cycle. Clear the slot. Load the hold counter with `BYTE_CYCLES*1`. Go to WAIT.
  - ISSUE_RES: drive `ser_C`/`ser_CTL` from the FIFO head for one cycle. Pop. Load the hold counter with `BYTE_CYCLES*5`. Go to WAIT.
  - WAIT: `ser_CTL=8'hFF`, `busy=1`. Decrement the counter each cycle. At 1, return to IDLE.
- Outputs are registered. `ser_CTL` equals 8'hFF in every state except ISSUE_*.
- Simultaneous events:
  - Push and pop in the same cycle are allowed, including when the FIFO is full. `res_ready` reflects pre-pop occupancy, so a full FIFO does not accept in its pop cycle.
  - An error arriving in the cycle its slot is cleared by ISSUE_ERR loads the slot; it is not an overflow.
- FIFO pointers use `$clog2(DEPTH)+1` bits. Full/empty come from MSB compare, and the pointers wrap silently.
- Reset mid-frame: all state returns to reset values immediately, and `ser_CTL` goes to 8'hFF asynchronously. The serializer is reset by the same `rst_n`.

## Timing
- Issue latency: the first result pushed at cycle t into an empty, idle block appears on `ser_*` at t+2 (push registers at t+1, issue registered at t+2).
- Issue cycles:
  - Normal frame issued at cycle i: the next issue occurs no earlier than i+1+55.
  - Error frame issued at cycle i: the next issue occurs no earlier than i+1+11.
- These gaps guarantee that the serializer has returned to its IDLE state when the next CTL byte is sampled.
- Back-to-back results stream with exactly that gap; there is no extra idle cycle.
- Priority is evaluated only in IDLE. A frame in flight is never pre-empted.

## Structure
- Package `mtm_alu_pkg` holds:
  - the error code constants `ERR_DATA`, `ERR_CRC` and `ERR_OP`;
  - `IDLE_CTL`;
  - `BYTE_CYCLES`;
  - the state enum (IDLE, ISSUE_ERR, ISSUE_RES, WAIT);
  - the function `is_err_code(ctl)`.
- Sub-module `mtm_Alu_res_fifo` (40-bit wide, `DEPTH` entries, push/pop/full/empty) is instantiated once. The scheduler FSM, error slot and hold counter live in the top.

## Test plan
- Single result `C=32'hDEADBEEF`, `CTL=8'h35` → `ser_CTL=8'h35`, `ser_C=32'hDEADBEEF` for one cycle at t+2, `busy` for 55 cycles; the serializer's `sout` shows 5 bytes: DE AD BE EF (packet bit 0), then 35 (packet bit 1).
- Error `8'b10010011` alone → one-cycle issue with `ser_C=0`, `busy` for 11 cycles; `sout` shows 1 byte with packet bit 1.
- Push 4 results while busy, then a fifth → `res_ready=0` on the fifth. All 4 issue in order, 56 cycles apart, and the fifth is accepted after the first pop.
- Result queued and error pending together in IDLE → error issues first; the result issues 12 cycles later.
- Two errors while busy → the first is issued; `err_overflow=1`. `res_CTL=8'h80` or `err_CTL=8'h00` → dropped, `bad_ctl=1`.
- Assert `rst_n` low mid-WAIT with 2 queued results → `ser_CTL=8'hFF`, `busy=0`, FIFO empty immediately. After release, a new result issues at t+2.

Source files
------------

// File: rtl/mtm_alu_pkg.sv
// Shared constants, types and helpers for the ALU output scheduler.
package mtm_alu_pkg;

    localparam int unsigned BYTE_CYCLES = 11;
    localparam int unsigned DATA_W      = 32;
    localparam int unsigned CTL_W       = 8;

    localparam logic [CTL_W-1:0] ERR_DATA = 8'b11001001;
    localparam logic [CTL_W-1:0] ERR_CRC  = 8'b10100101;
    localparam logic [CTL_W-1:0] ERR_OP   = 8'b10010011;
    localparam logic [CTL_W-1:0] IDLE_CTL = 8'hFF;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE_ERR,
        ISSUE_RES,
        WAIT
    } sched_state_t;

    // One buffered normal result: control byte above the data word.
    typedef struct packed {
        logic [CTL_W-1:0]  ctl;
        logic [DATA_W-1:0] c;
    } res_t;

    // True for the three legal error response codes.
    function automatic logic is_err_code(input logic [CTL_W-1:0] ctl);
        return (ctl == ERR_DATA) || (ctl == ERR_CRC) || (ctl == ERR_OP);
    endfunction

endpackage

// File: rtl/mtm_Alu_res_fifo.sv
// Small synchronous FIFO for normal results; extra pointer MSB separates full from empty.
module mtm_Alu_res_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 40
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata_c,
    output logic             o_full_c,
    output logic             o_empty_c
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_push = i_push && !o_full_c;
    assign w_do_pop  = i_pop && !o_empty_c;

    assign o_empty_c = (r_wr_ptr == r_rd_ptr);
    assign o_full_c  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_rdata_c = r_mem[r_rd_ptr[AW-1:0]];

    // Pointer update; pointers wrap naturally at 2*DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    // Storage write; contents are qualified by the pointers so no reset is needed.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
    end

endmodule

// File: rtl/mtm_alu_out_sched.sv
// Chooses the next serializer frame (error first), issues it for one cycle, then holds off for the frame.
module mtm_alu_out_sched #(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned BYTE_CYCLES = 11
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        res_valid,
    input  logic [31:0] res_C,
    input  logic [7:0]  res_CTL,
    output logic        res_ready,
    input  logic        err_valid,
    input  logic [7:0]  err_CTL,
    output logic [31:0] ser_C,
    output logic [7:0]  ser_CTL,
    output logic        busy,
    output logic        err_overflow,
    output logic        bad_ctl
);

    import mtm_alu_pkg::*;

    localparam int unsigned          CNT_W    = $clog2(5 * BYTE_CYCLES + 1);
    localparam logic [CNT_W-1:0]     RES_HOLD = CNT_W'(5 * BYTE_CYCLES);
    localparam logic [CNT_W-1:0]     ERR_HOLD = CNT_W'(BYTE_CYCLES);

    sched_state_t      r_state;
    sched_state_t      w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [31:0]       r_ser_C;
    logic [31:0]       w_ser_C_nxt;
    logic [7:0]        r_ser_CTL;
    logic [7:0]        w_ser_CTL_nxt;
    logic              r_busy;
    logic              w_busy_nxt;
    logic              r_slot_v;
    logic [7:0]        r_slot;
    logic              r_err_ovf;
    logic              r_bad_ctl;
    logic              w_launch;
    logic              w_pop;
    logic              w_slot_clr;
    logic              w_push;
    logic              w_full;
    logic              w_empty;
    logic              w_err_legal;
    res_t              w_wdata;
    res_t              w_head;

    assign res_ready    = !w_full;
    assign w_push       = res_valid && !w_full && !res_CTL[7];
    assign w_err_legal  = is_err_code(err_CTL);
    assign w_wdata      = '{ctl: res_CTL, c: res_C};

    assign ser_C        = r_ser_C;
    assign ser_CTL      = r_ser_CTL;
    assign busy         = r_busy;
    assign err_overflow = r_err_ovf;
    assign bad_ctl      = r_bad_ctl;

    mtm_Alu_res_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(res_t))
    ) u_res_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_push    (w_push),
        .i_wdata   (w_wdata),
        .i_pop     (w_pop),
        .o_rdata_c (w_head),
        .o_full_c  (w_full),
        .o_empty_c (w_empty)
    );

    // Next state and next registered outputs; the last WAIT cycle arbitrates like IDLE so frames stream without a gap.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_ser_C_nxt   = '0;
        w_ser_CTL_nxt = IDLE_CTL;
        w_busy_nxt    = 1'b0;
        w_pop         = 1'b0;
        w_slot_clr    = 1'b0;
        w_launch      = 1'b0;
        case (r_state)
            IDLE: w_launch = 1'b1;
            ISSUE_ERR: begin
                w_state_nxt = WAIT;
                w_cnt_nxt   = ERR_HOLD;
                w_busy_nxt  = 1'b1;
            end
            ISSUE_RES: begin
                w_state_nxt = WAIT;
                w_cnt_nxt   = RES_HOLD;
                w_busy_nxt  = 1'b1;
            end
            WAIT: begin
                w_cnt_nxt = r_cnt - CNT_W'(1);
                if (r_cnt == CNT_W'(1)) w_launch   = 1'b1;
                else                    w_busy_nxt = 1'b1;
            end
            default: w_state_nxt = IDLE;
        endcase
        if (w_launch) begin
            if (r_slot_v) begin
                w_state_nxt   = ISSUE_ERR;
                w_ser_CTL_nxt = r_slot;
                w_slot_clr    = 1'b1;
            end else if (!w_empty) begin
                w_state_nxt   = ISSUE_RES;
                w_ser_C_nxt   = w_head.c;
                w_ser_CTL_nxt = w_head.ctl;
                w_pop         = 1'b1;
            end else begin
                w_state_nxt   = IDLE;
            end
        end
    end

    // State, hold counter and serializer-facing output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_ser_C   <= '0;
            r_ser_CTL <= IDLE_CTL;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_ser_C   <= w_ser_C_nxt;
            r_ser_CTL <= w_ser_CTL_nxt;
            r_busy    <= w_busy_nxt;
        end
    end

    // Single error slot; an error arriving while the slot is being issued takes its place.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_slot_v  <= 1'b0;
            r_slot    <= IDLE_CTL;
            r_err_ovf <= 1'b0;
        end else if (err_valid && w_err_legal) begin
            if (r_slot_v && !w_slot_clr) begin
                r_err_ovf <= 1'b1;
            end else begin
                r_slot_v <= 1'b1;
                r_slot   <= err_CTL;
            end
        end else if (w_slot_clr) begin
            r_slot_v <= 1'b0;
        end
    end

    // Sticky flag for inputs dropped because of an illegal control byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bad_ctl <= 1'b0;
        end else if ((res_valid && !w_full && res_CTL[7]) || (err_valid && !w_err_legal)) begin
            r_bad_ctl <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mtm_alu_out_sched.sv
// Bench for the ALU output scheduler: queue-based reference model plus directed literal checks.
module tb_mtm_alu_out_sched;

    localparam int DEPTH   = 4;
    localparam int RES_GAP = 56;
    localparam int ERR_GAP = 12;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        res_valid = 1'b0;
    logic [31:0] res_C = '0;
    logic [7:0]  res_CTL = '0;
    logic        res_ready;
    logic        err_valid = 1'b0;
    logic [7:0]  err_CTL = '0;
    logic [31:0] ser_C;
    logic [7:0]  ser_CTL;
    logic        busy;
    logic        err_overflow;
    logic        bad_ctl;

    mtm_alu_out_sched #(.DEPTH(DEPTH), .BYTE_CYCLES(11)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .res_valid    (res_valid),
        .res_C        (res_C),
        .res_CTL      (res_CTL),
        .res_ready    (res_ready),
        .err_valid    (err_valid),
        .err_CTL      (err_CTL),
        .ser_C        (ser_C),
        .ser_CTL      (ser_CTL),
        .busy         (busy),
        .err_overflow (err_overflow),
        .bad_ctl      (bad_ctl)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    longint cyc = 0;

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk = n_chk + 1;
        if (act === exp) n_pass = n_pass + 1;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    // Reference model: pending results with the first cycle each may be issued.
    typedef struct {
        logic [7:0]  ctl;
        logic [31:0] c;
        longint      elig;
    } ent_t;

    ent_t        mq[$];
    logic        m_slot_v = 1'b0;
    logic [7:0]  m_slot = '0;
    longint      m_slot_elig = 0;
    logic        m_ovf = 1'b0;
    logic        m_bad = 1'b0;
    longint      m_next_free = 0;
    longint      m_last = -1000;
    logic        e_iss = 1'b0;
    logic [7:0]  e_ctl = '0;
    logic [31:0] e_c = '0;
    logic        ready_e;

    longint      log_cyc[$];
    logic [7:0]  log_ctl[$];

    // Mid-cycle compare against the model, then advance the model by one cycle.
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            mq.delete();
            m_slot_v    = 1'b0;
            m_ovf       = 1'b0;
            m_bad       = 1'b0;
            m_next_free = 0;
            m_last      = -1000;
            e_iss       = 1'b0;
            chk("rst_ser_CTL", 64'(ser_CTL), 64'(8'hFF));
            chk("rst_ser_C", 64'(ser_C), 64'(0));
            chk("rst_busy", 64'(busy), 64'(0));
            chk("rst_res_ready", 64'(res_ready), 64'(1));
        end else begin
            ready_e = (mq.size() < DEPTH);
            chk("m_ser_CTL", 64'(ser_CTL), e_iss ? 64'(e_ctl) : 64'(8'hFF));
            if (e_iss) chk("m_ser_C", 64'(ser_C), 64'(e_c));
            chk("m_busy", 64'(busy), 64'((cyc > m_last) && (cyc < m_next_free)));
            chk("m_res_ready", 64'(res_ready), 64'(ready_e));
            chk("m_err_overflow", 64'(err_overflow), 64'(m_ovf));
            chk("m_bad_ctl", 64'(bad_ctl), 64'(m_bad));
            if (ser_CTL != 8'hFF) begin
                log_cyc.push_back(cyc);
                log_ctl.push_back(ser_CTL);
            end
            e_iss = 1'b0;
            if (cyc + 1 >= m_next_free) begin
                if (m_slot_v && m_slot_elig <= cyc + 1) begin
                    e_iss       = 1'b1;
                    e_ctl       = m_slot;
                    e_c         = '0;
                    m_slot_v    = 1'b0;
                    m_last      = cyc + 1;
                    m_next_free = cyc + 1 + ERR_GAP;
                end else if (mq.size() > 0 && mq[0].elig <= cyc + 1) begin
                    e_iss       = 1'b1;
                    e_ctl       = mq[0].ctl;
                    e_c         = mq[0].c;
                    mq.delete(0);
                    m_last      = cyc + 1;
                    m_next_free = cyc + 1 + RES_GAP;
                end
            end
            if (res_valid && ready_e) begin
                if (res_CTL[7]) m_bad = 1'b1;
                else mq.push_back('{ctl: res_CTL, c: res_C, elig: cyc + 2});
            end
            if (err_valid) begin
                if (err_CTL inside {8'hC9, 8'h93, 8'hA5}) begin
                    if (m_slot_v) m_ovf = 1'b1;
                    else begin
                        m_slot_v    = 1'b1;
                        m_slot      = err_CTL;
                        m_slot_elig = cyc + 2;
                    end
                end else begin
                    m_bad = 1'b1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic push1(input logic [31:0] c, input logic [7:0] ctl);
        res_valid = 1'b1;
        res_C     = c;
        res_CTL   = ctl;
        tick();
        res_valid = 1'b0;
    endtask

    task automatic err1(input logic [7:0] ctl);
        err_valid = 1'b1;
        err_CTL   = ctl;
        tick();
        err_valid = 1'b0;
    endtask

    task automatic chk_log(input string nm, input int idx, input logic [7:0] ctl, input longint gap);
        if (log_ctl.size() <= idx) begin
            chk({nm, "_count"}, 64'(log_ctl.size()), 64'(idx + 1));
        end else begin
            chk({nm, "_ctl"}, 64'(log_ctl[idx]), 64'(ctl));
            if (idx > 0) chk({nm, "_gap"}, 64'(log_cyc[idx] - log_cyc[idx-1]), 64'(gap));
        end
    endtask

    int cnt;
    int waited;

    initial begin
        ticks(3);
        rst_n = 1'b1;
        ticks(2);

        // Single result: issue two cycles after the push, then 55 busy cycles.
        push1(32'hDEADBEEF, 8'h35);
        #3 chk("t1_not_yet", 64'(ser_CTL), 64'(8'hFF));
        tick();
        #3;
        chk("t1_ctl", 64'(ser_CTL), 64'(8'h35));
        chk("t1_c", 64'(ser_C), 64'(32'hDEADBEEF));
        cnt = 0;
        for (int i = 0; i < 70; i++) begin
            tick();
            if (busy) cnt++;
        end
        chk("t1_busy_len", 64'(cnt), 64'(55));

        // Lone error: one-cycle issue with zero data, 11 busy cycles.
        err1(8'b10010011);
        tick();
        #3;
        chk("t2_ctl", 64'(ser_CTL), 64'(8'h93));
        chk("t2_c", 64'(ser_C), 64'(0));
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (busy) cnt++;
        end
        chk("t2_busy_len", 64'(cnt), 64'(11));

        // Error arriving in the cycle the slot is issued reloads it without overflow.
        log_cyc.delete();
        log_ctl.delete();
        err1(8'hC9);
        err1(8'h93);
        ticks(25);
        chk_log("t6", 0, 8'hC9, 0);
        chk_log("t6", 1, 8'h93, 12);
        chk("t6_no_ovf", 64'(err_overflow), 64'(0));

        // Result and error pending together: error first, result 12 cycles later.
        log_cyc.delete();
        log_ctl.delete();
        res_valid = 1'b1;
        res_C     = 32'h12345678;
        res_CTL   = 8'h22;
        err_valid = 1'b1;
        err_CTL   = 8'hA5;
        tick();
        res_valid = 1'b0;
        err_valid = 1'b0;
        ticks(80);
        chk_log("t4", 0, 8'hA5, 0);
        chk_log("t4", 1, 8'h22, 12);

        // Fill the FIFO while busy; the fifth result waits for the first pop.
        log_cyc.delete();
        log_ctl.delete();
        push1(32'h0000_00A0, 8'h11);
        ticks(2);
        for (int i = 0; i < 4; i++) begin
            res_valid = 1'b1;
            res_C     = 32'h0000_0100 + 32'(i);
            res_CTL   = 8'h12 + 8'(i);
            tick();
        end
        res_valid = 1'b1;
        res_C     = 32'h0000_0F00;
        res_CTL   = 8'h16;
        chk("t3_full_ready", 64'(res_ready), 64'(0));
        waited = 0;
        while (!res_ready && waited < 200) begin
            tick();
            waited++;
        end
        chk("t3_ready_back", 64'(res_ready), 64'(1));
        chk("t3_accept_wait", 64'(waited), 64'(51));
        tick();
        res_valid = 1'b0;
        ticks(6 * RES_GAP);
        for (int i = 0; i < 6; i++) chk_log("t3", i, 8'h11 + 8'(i), 56);

        // Two errors while busy: first kept, overflow flagged; illegal CTLs dropped.
        log_cyc.delete();
        log_ctl.delete();
        push1(32'h0000_0030, 8'h30);
        ticks(2);
        err1(8'hA5);
        err1(8'hC9);
        #3 chk("t5_ovf", 64'(err_overflow), 64'(1));
        chk("t5_bad_before", 64'(bad_ctl), 64'(0));
        tick();
        push1(32'h0000_0080, 8'h80);
        err1(8'h00);
        #3 chk("t5_bad", 64'(bad_ctl), 64'(1));
        ticks(80);
        chk_log("t5", 0, 8'h30, 0);
        chk_log("t5", 1, 8'hA5, 56);
        chk("t5_log_len", 64'(log_ctl.size()), 64'(2));

        // Reset in the middle of a frame with two results queued.
        push1(32'h0000_0040, 8'h40);
        ticks(2);
        push1(32'h0000_0041, 8'h41);
        push1(32'h0000_0042, 8'h42);
        ticks(5);
        #2 rst_n = 1'b0;
        #1;
        chk("t7_ctl_async", 64'(ser_CTL), 64'(8'hFF));
        chk("t7_busy_async", 64'(busy), 64'(0));
        chk("t7_ready_async", 64'(res_ready), 64'(1));
        chk("t7_flags_clr", 64'({err_overflow, bad_ctl}), 64'(0));
        log_cyc.delete();
        log_ctl.delete();
        ticks(2);
        rst_n = 1'b1;
        tick();
        push1(32'hCAFEF00D, 8'h50);
        tick();
        #3;
        chk("t7_ctl_after", 64'(ser_CTL), 64'(8'h50));
        chk("t7_c_after", 64'(ser_C), 64'(32'hCAFEF00D));
        ticks(120);
        chk("t7_log_len", 64'(log_ctl.size()), 64'(1));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
